// File: rtl/avalon_m_block_xfer.sv
// -----------------------------------------------------------------------------
// avalon_m_block_xfer
//
// Avalon-MM master that moves one 1024-bit block (32 x 32-bit words) between a
// local command port and an Avalon-MM slave. A write command issues 32
// single-word writes. A read command issues 32 pipelined reads, keeping at most
// MAX_PENDING requests outstanding, and assembles the responses into rd_block.
//
// Parameters
//   MAX_PENDING : maximum outstanding read requests (1..8)
//   ADDR_W      : Avalon byte-address width
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   cmd_write           : 1 = write block to slave, 0 = read block from slave
//   cmd_addr            : base byte address, bits [1:0] ignored
//   wr_block            : write payload, captured on command accept
//   rd_block            : read result register (word i = bits 32*i+31:32*i)
//   done                : one-cycle pulse when a block transfer completes
//   avm_*               : Avalon-MM master signals, all registered except the
//                         constant byteenable
// -----------------------------------------------------------------------------
module avalon_m_block_xfer #(
  parameter int MAX_PENDING = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1023:0]     wr_block,
  output logic [1023:0]     rd_block,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [5:0]        WORD_COUNT = 6'd32;
  localparam logic [3:0]        PEND_LIMIT = 4'(MAX_PENDING);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(2'b11));

  // Byte address of word idx; the addition wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [4:0]        idx);
    word_addr = base + ADDR_W'({idx, 2'b00});
  endfunction

  // Registered state
  state_t              state_r;
  logic [5:0]          wi_r;        // write word index (0..32)
  logic [5:0]          ri_r;        // read issue index (0..32)
  logic [5:0]          rx_r;        // read receive index (0..32)
  logic [3:0]          pend_r;      // outstanding read requests
  logic [ADDR_W-1:0]   base_r;
  logic [1023:0]       wr_buf_r;
  logic [1023:0]       rd_block_r;
  logic [ADDR_W-1:0]   avm_address_r;
  logic [31:0]         avm_writedata_r;
  logic                avm_read_r;
  logic                avm_write_r;
  logic                done_r;
  logic                cmd_ready_r;

  // Next-state values
  state_t              state_s;
  logic [5:0]          wi_s;
  logic [5:0]          ri_s;
  logic [5:0]          rx_s;
  logic [3:0]          pend_s;
  logic [ADDR_W-1:0]   base_s;
  logic [1023:0]       wr_buf_s;
  logic [1023:0]       rd_block_s;
  logic [ADDR_W-1:0]   avm_address_s;
  logic [31:0]         avm_writedata_s;
  logic                avm_read_s;
  logic                avm_write_s;
  logic                done_s;
  logic                cmd_ready_s;
  logic                req_acc_s;   // read request taken by the slave this cycle
  logic                rsp_s;       // read response counted this cycle

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_s         = state_r;
    wi_s            = wi_r;
    ri_s            = ri_r;
    rx_s            = rx_r;
    pend_s          = pend_r;
    base_s          = base_r;
    wr_buf_s        = wr_buf_r;
    rd_block_s      = rd_block_r;
    avm_address_s   = avm_address_r;
    avm_writedata_s = avm_writedata_r;
    avm_read_s      = 1'b0;
    avm_write_s     = 1'b0;
    done_s          = 1'b0;
    req_acc_s       = 1'b0;
    rsp_s           = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          base_s        = cmd_addr & ALIGN_MASK;
          wi_s          = 6'd0;
          ri_s          = 6'd0;
          rx_s          = 6'd0;
          pend_s        = 4'd0;
          avm_address_s = cmd_addr & ALIGN_MASK;
          if (cmd_write) begin
            state_s         = ST_WRITE;
            wr_buf_s        = wr_block;
            avm_write_s     = 1'b1;
            avm_writedata_s = wr_block[31:0];
          end else begin
            // MAX_PENDING >= 1, so the first read can always go out.
            state_s    = ST_READ;
            avm_read_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (avm_write_r && !avm_waitrequest) begin
          wi_s = wi_r + 6'd1;
        end else begin
          wi_s = wi_r;
        end
        if (wi_s == WORD_COUNT) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          // While stalled wi_s == wi_r, so address and data repeat unchanged.
          avm_write_s     = 1'b1;
          avm_address_s   = word_addr(base_r, wi_s[4:0]);
          avm_writedata_s = wr_buf_r[{wi_s[4:0], 5'b00000} +: 32];
        end
      end

      ST_READ: begin
        req_acc_s = avm_read_r && !avm_waitrequest;
        rsp_s     = avm_readdatavalid && (pend_r != 4'd0);
        ri_s      = ri_r + {5'b00000, req_acc_s};
        pend_s    = pend_r + {3'b000, req_acc_s} - {3'b000, rsp_s};
        if (rsp_s) begin
          rd_block_s[{rx_r[4:0], 5'b00000} +: 32] = avm_readdata;
          rx_s = rx_r + 6'd1;
        end else begin
          rx_s = rx_r;
        end
        if (rx_s == WORD_COUNT) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else begin
          // A stalled request keeps avm_read high: pend cannot grow while
          // stalled, so the window condition that raised it still holds.
          avm_read_s = (ri_s < WORD_COUNT) && (pend_s < PEND_LIMIT);
          if (avm_read_s) begin
            avm_address_s = word_addr(base_r, ri_s[4:0]);
          end else begin
            avm_address_s = avm_address_r;
          end
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    cmd_ready_s = (state_s == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      wi_r            <= 6'd0;
      ri_r            <= 6'd0;
      rx_r            <= 6'd0;
      pend_r          <= 4'd0;
      base_r          <= '0;
      wr_buf_r        <= 1024'd0;
      rd_block_r      <= 1024'd0;
      avm_address_r   <= '0;
      avm_writedata_r <= 32'd0;
      avm_read_r      <= 1'b0;
      avm_write_r     <= 1'b0;
      done_r          <= 1'b0;
      cmd_ready_r     <= 1'b1;
    end else begin
      state_r         <= state_s;
      wi_r            <= wi_s;
      ri_r            <= ri_s;
      rx_r            <= rx_s;
      pend_r          <= pend_s;
      base_r          <= base_s;
      wr_buf_r        <= wr_buf_s;
      rd_block_r      <= rd_block_s;
      avm_address_r   <= avm_address_s;
      avm_writedata_r <= avm_writedata_s;
      avm_read_r      <= avm_read_s;
      avm_write_r     <= avm_write_s;
      done_r          <= done_s;
      cmd_ready_r     <= cmd_ready_s;
    end
  end

  assign cmd_ready      = cmd_ready_r;
  assign done           = done_r;
  assign rd_block       = rd_block_r;
  assign avm_address    = avm_address_r;
  assign avm_read       = avm_read_r;
  assign avm_write      = avm_write_r;
  assign avm_writedata  = avm_writedata_r;
  assign avm_byteenable = 4'hF;

endmodule

// File: tb/tb_avalon_m_block_xfer.sv
// -----------------------------------------------------------------------------
// tb_avalon_m_block_xfer
//
// Self-checking bench for avalon_m_block_xfer. A transaction-level model keeps
// per-command counts (writes taken, reads issued, responses delivered) and the
// expected rd_block contents; every cycle the DUT outputs are compared with
// what those counts imply. A behavioural Avalon slave with configurable
// latency, waitrequest pattern and stray readdatavalid pulses drives the bus.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_avalon_m_block_xfer;

  localparam int MAXP = 4;
  localparam int AW   = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [1023:0]   wr_block;
  logic [1023:0]   rd_block;
  logic            done;
  logic [AW-1:0]   avm_address;
  logic            avm_read;
  logic            avm_write;
  logic [31:0]     avm_writedata;
  logic [3:0]      avm_byteenable;
  logic [31:0]     avm_readdata;
  logic            avm_readdatavalid;
  logic            avm_waitrequest;

  avalon_m_block_xfer #(.MAX_PENDING(MAXP), .ADDR_W(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .wr_block          (wr_block),
    .rd_block          (rd_block),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_waitrequest   (avm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Transaction-level model
  bit          busy, finishing, is_w, exp_done, was_reset;
  logic [31:0] base;
  logic [31:0] wwords [32];
  logic [31:0] rdm    [32];
  int          wacc, racc, rrsp;
  int          acc_cyc, done_cyc, done_cnt, first_racc_cyc, last_racc_cyc, max_pend;
  logic [31:0] wlog_addr [$];
  logic [31:0] wlog_data [$];
  logic [31:0] rlog      [$];

  // Slave model
  int          rq_due  [$];
  logic [31:0] rq_data [$];
  int          lat, wait_mode, last_w, scnt;
  bit          strays;
  logic [31:0] salt;

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  function automatic logic [1023:0] model_block();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[32*i +: 32] = rdm[i];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int i = 0; i < 32; i++) begin
        if (act[32*i +: 32] !== exp[32*i +: 32]) begin
          $display("FAIL %s cyc=%0d word %0d actual=%h expected=%h",
                   name, cyc, i, act[32*i +: 32], exp[32*i +: 32]);
          break;
        end
      end
    end
  endtask

  // Account for what the coming clock edge does, from the values now on the bus.
  task automatic pre_edge();
    int pend_before;
    exp_done  = 1'b0;
    was_reset = reset;
    if (reset) begin
      busy = 1'b0; finishing = 1'b0;
      wacc = 0; racc = 0; rrsp = 0;
      for (int i = 0; i < 32; i++) rdm[i] = 32'h0;
      rq_due.delete(); rq_data.delete();
    end else if (finishing) begin
      busy = 1'b0; finishing = 1'b0;
    end else if (!busy) begin
      if (cmd_valid) begin
        busy = 1'b1; is_w = cmd_write;
        base = cmd_addr & 32'hFFFF_FFFC;
        wacc = 0; racc = 0; rrsp = 0;
        acc_cyc = cyc;
        for (int i = 0; i < 32; i++) wwords[i] = wr_block[32*i +: 32];
      end
    end else if (is_w) begin
      if (avm_write && !avm_waitrequest) begin
        wlog_addr.push_back(avm_address);
        wlog_data.push_back(avm_writedata);
        wacc++;
        if (wacc == 32) begin exp_done = 1'b1; finishing = 1'b1; end
      end
    end else begin
      pend_before = racc - rrsp;
      if (avm_readdatavalid && pend_before > 0) begin
        rdm[rrsp] = avm_readdata;
        rrsp++;
      end
      if (avm_read && !avm_waitrequest) begin
        if (racc == 0) first_racc_cyc = cyc;
        last_racc_cyc = cyc;
        rlog.push_back(avm_address);
        rq_due.push_back(cyc + lat);
        rq_data.push_back(slave_word(avm_address));
        racc++;
      end
      if (racc - rrsp > max_pend) max_pend = racc - rrsp;
      if (rrsp == 32) begin exp_done = 1'b1; finishing = 1'b1; end
    end
  endtask

  // Compare DUT outputs after the edge, then drive the slave side for the next one.
  task automatic post_edge();
    bit active, exp_rd;
    cyc++;
    chk("byteenable", 32'(avm_byteenable), 32'h0000_000F);
    if (was_reset) begin
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_avm_read", 32'(avm_read), 32'd0);
      chk("rst_avm_write", 32'(avm_write), 32'd0);
      chk("rst_avm_address", avm_address, 32'h0);
      chk("rst_avm_writedata", avm_writedata, 32'h0);
      chk_blk("rst_rd_block", rd_block, 1024'd0);
    end else begin
      active = busy && !finishing;
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
      chk("done", 32'(done), 32'(exp_done));
      if (done) begin done_cnt++; done_cyc = cyc; end
      chk("avm_write", 32'(avm_write), 32'(active && is_w));
      if (active && is_w) begin
        chk("wr_address", avm_address, base + 32'(4 * wacc));
        chk("wr_data", avm_writedata, wwords[wacc]);
      end
      exp_rd = active && !is_w && (racc < 32) && ((racc - rrsp) < MAXP);
      chk("avm_read", 32'(avm_read), 32'(exp_rd));
      if (exp_rd) chk("rd_address", avm_address, base + 32'(4 * racc));
      chk_blk("rd_block", rd_block, model_block());
    end

    case (wait_mode)
      1: begin
        if (wacc != last_w) begin last_w = wacc; scnt = 0; end
        avm_waitrequest = busy && !finishing && is_w && (wacc % 4 == 3) && (scnt < 3);
        if (avm_waitrequest) scnt++;
      end
      2: avm_waitrequest = ($urandom_range(0, 3) == 0);
      default: avm_waitrequest = 1'b0;
    endcase

    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = rq_data.pop_front();
      void'(rq_due.pop_front());
    end else if (strays && rq_due.size() == 0 && $urandom_range(0, 3) == 0) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = $urandom;
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
    end
  endtask

  task automatic step();
    pre_edge();
    @(posedge clk);
    #1;
    post_edge();
  endtask

  task automatic run_cmd(input bit w, input logic [31:0] a, input logic [1023:0] b);
    int n;
    int start;
    wlog_addr.delete(); wlog_data.delete(); rlog.delete();
    max_pend = 0; last_w = -1; scnt = 0;
    start = done_cnt;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; wr_block = b;
    step();
    // Scramble the command inputs so anything not latched at accept shows up.
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; wr_block = ~b;
    n = 0;
    while (done_cnt == start && n < 3000) begin step(); n++; end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL done_timeout cyc=%0d actual=no_done expected=done", cyc);
    end
    step(); step();
    chk("done_once", 32'(done_cnt - start), 32'd1);
  endtask

  task automatic check_read_result(input string name);
    logic [1023:0] e;
    for (int i = 0; i < 32; i++) e[32*i +: 32] = slave_word(base + 32'(4 * i));
    chk_blk(name, rd_block, e);
  endtask

  logic [1023:0] blk;
  int            n;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; wr_block = 1024'd0;
    avm_readdata = 32'h0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    wait_mode = 0; lat = 2; strays = 1'b0; salt = 32'h0;
    busy = 1'b0; finishing = 1'b0; is_w = 1'b0; base = 32'h0;
    wacc = 0; racc = 0; rrsp = 0; done_cnt = 0; done_cyc = 0; acc_cyc = 0;
    first_racc_cyc = 0; last_racc_cyc = 0; max_pend = 0; last_w = -1; scnt = 0;
    for (int i = 0; i < 32; i++) begin rdm[i] = 32'h0; wwords[i] = 32'h0; end

    step(); step();
    reset = 1'b0;
    step();

    // Write, no stall
    for (int i = 0; i < 32; i++) blk[32*i +: 32] = 32'hA500_0000 + 32'(i);
    run_cmd(1'b1, 32'h0000_1000, blk);
    chk("w_done_latency", 32'(done_cyc - acc_cyc), 32'd33);
    chk("w_count", 32'(wlog_addr.size()), 32'd32);
    chk("w_first_addr", wlog_addr[0], 32'h0000_1000);
    chk("w_first_data", wlog_data[0], 32'hA500_0000);
    chk("w_last_addr", wlog_addr[31], 32'h0000_107C);
    chk("w_last_data", wlog_data[31], 32'hA500_001F);

    // Write, 3-cycle stall on every 4th word (words 3,7,..,31 -> 8 stalls)
    wait_mode = 1;
    for (int i = 0; i < 32; i++) blk[32*i +: 32] = $urandom;
    run_cmd(1'b1, 32'h0000_8002, blk);
    chk("ws_done_latency", 32'(done_cyc - acc_cyc), 32'd57);
    chk("ws_count", 32'(wlog_addr.size()), 32'd32);
    chk("ws_addr0", wlog_addr[0], 32'h0000_8000);
    chk("ws_data31", wlog_data[31], blk[1023:992]);

    // Pipelined read, latency 2
    wait_mode = 0; lat = 2; salt = 32'h0;
    run_cmd(1'b0, 32'h0000_2000, 1024'd0);
    check_read_result("r2_block");
    chk("r2_word5", rd_block[191:160], 32'h0000_2014);
    chk("r2_word31", rd_block[1023:992], 32'h0000_207C);
    chk("r2_max_pend", 32'(max_pend), 32'd2);
    chk("r2_issue_span", 32'(last_racc_cyc - first_racc_cyc), 32'd31);
    chk("r2_done_latency", 32'(done_cyc - acc_cyc), 32'd35);

    // Read, latency 6 > MAX_PENDING
    lat = 6; salt = 32'h5A5A_0000;
    run_cmd(1'b0, 32'h0000_3000, 1024'd0);
    check_read_result("r6_block");
    chk("r6_max_pend", 32'(max_pend), 32'd4);
    chk("r6_paused", 32'(last_racc_cyc - first_racc_cyc > 31), 32'd1);

    // Wrap-around read
    lat = 3; salt = 32'h0;
    run_cmd(1'b0, 32'hFFFF_FFF0, 1024'd0);
    check_read_result("wrap_block");
    chk("wrap_addr3", rlog[3], 32'hFFFF_FFFC);
    chk("wrap_addr4", rlog[4], 32'h0000_0000);
    chk("wrap_addr31", rlog[31], 32'h0000_006C);

    // Randomised commands with random stalls, latency and stray responses
    wait_mode = 2; strays = 1'b1;
    for (int t = 0; t < 10; t++) begin
      lat  = $urandom_range(1, 7);
      salt = $urandom;
      for (int i = 0; i < 32; i++) blk[32*i +: 32] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        run_cmd(1'b1, $urandom, blk);
        chk("rnd_w_count", 32'(wlog_addr.size()), 32'd32);
      end else begin
        run_cmd(1'b0, $urandom, blk);
        check_read_result("rnd_r_block");
      end
    end

    // Reset in the middle of a read, then stray responses, then a fresh write
    wait_mode = 0; strays = 1'b0; lat = 2; salt = 32'h0;
    wlog_addr.delete(); wlog_data.delete(); rlog.delete();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_6000;
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (racc < 10 && n < 200) begin step(); n++; end
    chk("rst_reached_word10", 32'(racc >= 10), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    strays = 1'b1;
    for (int i = 0; i < 12; i++) step();
    strays = 1'b0;
    chk_blk("rst_strays_rd_block", rd_block, 1024'd0);
    chk("rst_strays_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 32; i++) blk[32*i +: 32] = $urandom;
    run_cmd(1'b1, 32'h0000_5000, blk);
    chk("post_rst_w_count", 32'(wlog_addr.size()), 32'd32);
    chk("post_rst_w_last_addr", wlog_addr[31], 32'h0000_507C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_m_block_xfer.md
# avalon_m_block_xfer

Avalon-MM master that moves one 1024-bit block (32 × 32-bit words, 128 bytes) between a local command interface and an Avalon-MM slave, as single-word write or pipelined read transfers. It is the initiator side of the curl calc unit's Avalon-MM slave interface and uses the same bit8/bit32/bit128/bit1024 data granularity. It serves as the in-design data mover and as the reference master for exercising the slave.

## Interface
Parameters:
- MAX_PENDING, 4: maximum outstanding read requests (1..8).
- ADDR_W, 32: Avalon byte-address width.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; the command is accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write block to slave, 0 = read block from slave.
- cmd_addr  in  ADDR_W  base byte address; bits [1:0] are ignored (treated as 0).
- wr_block  in  1024  write payload, sampled on command accept.
- rd_block  out  1024  read result register.
- done  out  1  one-cycle pulse when the block transfer completes.
- avm_address  out  ADDR_W  word-aligned byte address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  constant 4'hF.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read response strobe.
- avm_waitrequest  in  1  slave stall.

## Operation
- Word mapping: word i (0..31) = block[32*i+31 : 32*i], at address base + 4*i, modulo 2^ADDR_W (wrap-around permitted).
- FSM states: IDLE, WRITE, READ, DONE.
- Transitions:
  - IDLE → WRITE or READ on accept, selected by cmd_write. Base address is latched. For a write, wr_block is latched.
  - WRITE → DONE after word 31 is accepted.
  - READ → DONE after the 32nd response.
  - DONE → IDLE unconditionally.
- WRITE:
  - avm_write = 1 with avm_address and avm_writedata for word wi.
  - All three are held stable while avm_waitrequest = 1.
  - wi increments on each cycle with avm_write && !avm_waitrequest.
- READ request side:
  - Issue index ri (0..32) and outstanding counter pend (0..MAX_PENDING).
  - avm_read = 1 while ri < 32 and pend < MAX_PENDING.
  - A request is accepted when avm_read && !avm_waitrequest: ri++ and pend++.
  - Address is held stable while stalled.
  - When pend reaches MAX_PENDING, avm_read drops only after the current request is accepted. A request never abandons a stalled cycle.
- READ response side:
  - avm_readdatavalid with pend > 0 writes avm_readdata into rd_block word rx, then rx++ and pend--.
  - Request accept and response in the same cycle leave pend unchanged.
  - Responses are in order.
- Ignored responses: avm_readdatavalid while pend == 0, or in IDLE/WRITE/DONE.
- DONE: done = 1 for one cycle. rd_block holds its value until the next read writes it; words not yet rewritten keep their old values.
- Commands presented outside IDLE are not accepted (cmd_ready = 0).

## Timing
- Reset values: cmd_ready = 1, done = 0, avm_read = 0, avm_write = 0, avm_address = 0, avm_writedata = 0, rd_block = 0. Counters clear and the FSM is in IDLE.
- Reset mid-transfer: on the next edge, avm_read and avm_write are 0 and the FSM is in IDLE. Late responses from the slave are then ignored.
- Request timing: the first avm request is asserted the cycle after command accept, and all avm outputs are registered.
- Write latency with no waitrequest: avm_write is high for 32 consecutive cycles. done is high the cycle after the last accept. cmd_ready is high the cycle after done.
- Read throughput: with no waitrequest and a fixed slave latency L, reads sustain 1 word/cycle if L < MAX_PENDING.
- Read data visibility: a word received on edge n is visible on rd_block after that edge. done is asserted the cycle after the 32nd response.

## Test plan
- Write, no stall: addr 0x1000, wr_block word i = 0xA5000000 + i → 32 writes at 0x1000..0x107C with matching data, byteenable = 4'hF, done 33 cycles after accept.
- Write with stalls: waitrequest high 3 cycles on every 4th word → address and data stable during each stall, no word skipped or duplicated, done exactly once.
- Pipelined read, latency 2, MAX_PENDING = 4: slave returns word = address → rd_block word i = base + 4*i, pend never exceeds 4, back-to-back issue.
- Read, latency 6 > MAX_PENDING: avm_read pauses at pend = 4, resumes on responses, all 32 words correct, done exactly once.
- Wrap-around: base 0xFFFFFFF0 with a read → addresses 0xFFFFFFF0..0xFFFFFFFC then 0x00000000..0x0000006C.
- Reset at word 10 of a read, with stray readdatavalid pulses afterwards → next cycle idle outputs and cmd_ready = 1, strays ignored, rd_block = 0. A new write then completes correctly.
